opsum_glb_writer: RTL and testbench

Downstream drain stage for the 32-lane opsum FIFO bank. It round-robins across lanes, pops 16-bit partial sums in pairs, and packs each pair into a 32-bit word. Each word is written to the global buffer (GLB) at a per-lane address. One `start` pulse drains a fixed number of words per lane, then pulses `done`.

---
 rtl/opsum_wb_pkg.sv | 23 ++
 rtl/rr_lane_picker.sv | 26 ++
 rtl/opsum_glb_writer.sv | 172 +++++++++++++++++
 tb/tb_opsum_glb_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_wb_pkg.sv
// rtl/opsum_wb_pkg.sv - shared constants, lane index type and FSM states for the opsum GLB writer
package opsum_wb_pkg;

    localparam int NUM_LANES  = 32;
    localparam int LANE_W     = 16;
    localparam int GLB_DW     = 2 * LANE_W;
    localparam int LANE_IDX_W = $clog2(NUM_LANES);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        POP_HI,
        WRITE,
        DONE
    } wb_state_e;

    function automatic lane_idx_t next_lane(input lane_idx_t l);
        return (int'(l) == NUM_LANES - 1) ? '0 : l + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// rtl/rr_lane_picker.sv - first eligible lane at or after rr_ptr, wrapping modulo NUM_LANES
module rr_lane_picker
    import opsum_wb_pkg::*;
(
    input  lane_idx_t            rr_ptr,
    input  logic [NUM_LANES-1:0] eligible,
    output logic                 found,
    output lane_idx_t            idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = rr_ptr;
        cand  = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_LANES;
            if (!found && eligible[lane_idx_t'(cand)]) begin
                found = 1'b1;
                idx   = lane_idx_t'(cand);
            end
        end
    end

endmodule

// File: rtl/opsum_glb_writer.sv
// rtl/opsum_glb_writer.sv - drains the opsum FIFO bank in lane pairs into 32-bit GLB writes
module opsum_glb_writer
    import opsum_wb_pkg::*;
#(
    parameter int NUM_LANES = 32,
    parameter int LANE_W    = 16,
    parameter int GLB_DW    = 32,
    parameter int GLB_AW    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [GLB_AW-1:0]           base_addr,
    input  logic [GLB_AW-1:0]           lane_stride,
    input  logic [15:0]                 words_per_lane,
    input  logic [NUM_LANES-1:0]        opsum_fifo_empty,
    input  logic [NUM_LANES-1:0][31:0]  pop_opsum_data,
    output logic [NUM_LANES-1:0]        pop_opsum_en,
    output logic [NUM_LANES-1:0]        pop_opsum_mod,
    output logic                        glb_we,
    output logic [GLB_AW-1:0]           glb_addr,
    output logic [GLB_DW-1:0]           glb_wdata,
    input  logic                        glb_ready,
    output logic                        busy,
    output logic                        done
);

    wb_state_e              state;
    wb_state_e              state_n;
    lane_idx_t              rr_ptr;
    lane_idx_t              lane_q;
    lane_idx_t              pick_idx;
    logic                   pick_found;
    logic [GLB_AW-1:0]      base_q;
    logic [GLB_AW-1:0]      stride_q;
    logic [GLB_AW-1:0]      addr_calc;
    logic [15:0]            wpl_q;
    logic [15:0]            wcnt [NUM_LANES];
    logic [LANE_W-1:0]      lo_q;
    logic [NUM_LANES-1:0]   eligible;
    logic                   all_done;
    logic [NUM_LANES-1:0]   unused_hi;

    // Only the low LANE_W bits of each pop word carry an opsum.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_unused
        assign unused_hi[g] = ^pop_opsum_data[g][31:LANE_W];
    end

    assign pop_opsum_mod = '0;

    always_comb begin
        eligible = '0;
        all_done = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
            eligible[l] = !opsum_fifo_empty[l] && (wcnt[l] < wpl_q);
            if (wcnt[l] != wpl_q) begin
                all_done = 1'b0;
            end
        end
    end

    rr_lane_picker u_picker (
        .rr_ptr   (rr_ptr),
        .eligible (eligible),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Lane product wraps at GLB_AW bits, as does the final sum.
    assign addr_calc = base_q + GLB_AW'(lane_q) * stride_q + GLB_AW'({wcnt[lane_q], 2'b00});

    always_comb begin
        state_n      = state;
        pop_opsum_en = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ARB;
                end
            end
            ARB: begin
                if (all_done) begin
                    state_n = DONE;
                end else if (pick_found) begin
                    pop_opsum_en[pick_idx] = 1'b1;
                    state_n                = POP_HI;
                end
            end
            POP_HI: begin
                if (!opsum_fifo_empty[lane_q]) begin
                    pop_opsum_en[lane_q] = 1'b1;
                    state_n              = WRITE;
                end
            end
            WRITE: begin
                if (glb_ready) begin
                    state_n = ARB;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // A pop in the reset cycle would lose data the bank believes delivered.
        if (rst) begin
            pop_opsum_en = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lane_q    <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            wpl_q     <= '0;
            lo_q      <= '0;
            glb_we    <= 1'b0;
            glb_addr  <= '0;
            glb_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                wcnt[l] <= '0;
            end
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        stride_q <= lane_stride;
                        wpl_q    <= words_per_lane;
                        rr_ptr   <= '0;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            wcnt[l] <= '0;
                        end
                    end
                end
                ARB: begin
                    if (!all_done && pick_found) begin
                        lane_q <= pick_idx;
                        lo_q   <= pop_opsum_data[pick_idx][LANE_W-1:0];
                    end
                end
                POP_HI: begin
                    if (!opsum_fifo_empty[lane_q]) begin
                        glb_wdata <= GLB_DW'({pop_opsum_data[lane_q][LANE_W-1:0], lo_q});
                        glb_addr  <= addr_calc;
                        glb_we    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (glb_ready) begin
                        glb_we       <= 1'b0;
                        wcnt[lane_q] <= wcnt[lane_q] + 16'd1;
                        rr_ptr       <= next_lane(lane_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opsum_glb_writer.sv
// tb/tb_opsum_glb_writer.sv - directed self-checking bench for opsum_glb_writer
module tb_opsum_glb_writer;

    localparam int NL = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [31:0]          base_addr;
    logic [31:0]          lane_stride;
    logic [15:0]          words_per_lane;
    logic [NL-1:0]        opsum_fifo_empty;
    logic [NL-1:0][31:0]  pop_opsum_data;
    logic [NL-1:0]        pop_opsum_en;
    logic [NL-1:0]        pop_opsum_mod;
    logic                 glb_we;
    logic [31:0]          glb_addr;
    logic [31:0]          glb_wdata;
    logic                 glb_ready;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    opsum_glb_writer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_addr        (base_addr),
        .lane_stride      (lane_stride),
        .words_per_lane   (words_per_lane),
        .opsum_fifo_empty (opsum_fifo_empty),
        .pop_opsum_data   (pop_opsum_data),
        .pop_opsum_en     (pop_opsum_en),
        .pop_opsum_mod    (pop_opsum_mod),
        .glb_we           (glb_we),
        .glb_addr         (glb_addr),
        .glb_wdata        (glb_wdata),
        .glb_ready        (glb_ready),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        int              wpl;
        logic [31:0]     base;
        logic [31:0]     stride;
        int              la;
        int              na;
        logic [63:0]     va;
        int              lb;
        int              nb;
        logic [63:0]     vb;
        int              nexp;
        logic [1:0][31:0] ea;
        logic [1:0][31:0] ed;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] mem [NL][8];
    int          rdp [NL];
    int          wrp [NL];
    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    int          wr_n, npops, ndone, viol_empty, viol_onehot, cycles;
    int          ntests, nfail;

    function automatic vec_t mk(input int wpl, input logic [31:0] base, input logic [31:0] stride,
                                input int la, input int na, input logic [63:0] va,
                                input int lb, input int nb, input logic [63:0] vb,
                                input int nexp, input logic [63:0] ea, input logic [63:0] ed);
        vec_t v;
        v.wpl = wpl; v.base = base; v.stride = stride;
        v.la = la; v.na = na; v.va = va;
        v.lb = lb; v.nb = nb; v.vb = vb;
        v.nexp = nexp; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int l = 0; l < NL; l++) begin
            opsum_fifo_empty[l] = (rdp[l] == wrp[l]);
            pop_opsum_data[l]   = (rdp[l] == wrp[l]) ? 32'hDEAD_BEEF : {16'hC0DE, mem[l][rdp[l]]};
        end
    endtask

    task automatic push(input int l, input logic [15:0] v);
        if (wrp[l] < 8) begin
            mem[l][wrp[l]] = v;
            wrp[l]++;
        end
        drive();
    endtask

    // Outputs sampled at negedge; bank pops applied just after the posedge that consumed them.
    task automatic tick();
        logic [NL-1:0] pv;
        @(negedge clk);
        pv = pop_opsum_en;
        if ($countones(pv) > 1) viol_onehot++;
        for (int l = 0; l < NL; l++) begin
            if (pv[l] && rdp[l] == wrp[l]) viol_empty++;
        end
        if (glb_we && glb_ready && wr_n < 256) begin
            wr_addr[wr_n] = glb_addr;
            wr_data[wr_n] = glb_wdata;
            wr_n++;
        end
        if (done) ndone++;
        @(posedge clk);
        #1;
        npops += $countones(pv);
        for (int l = 0; l < NL; l++) begin
            if (pv[l] && rdp[l] != wrp[l]) rdp[l]++;
        end
        cycles++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        glb_ready = 1'b1;
        for (int l = 0; l < NL; l++) begin
            rdp[l] = 0;
            wrp[l] = 0;
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        wr_n = 0;
        npops = 0;
        ndone = 0;
    endtask

    task automatic start_drain(input int wpl, input logic [31:0] base, input logic [31:0] stride);
        words_per_lane = 16'(wpl);
        base_addr = base;
        lane_stride = stride;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] seen;
        logic [31:0] off;
        logic [31:0] expd;
        logic [7:0]  l8;
        int          bad, ln, w, p0, s;

        ntests = 0; nfail = 0; wr_n = 0; npops = 0; ndone = 0;
        viol_empty = 0; viol_onehot = 0; cycles = 0;
        rst = 1'b1; start = 1'b0; glb_ready = 1'b1;
        base_addr = 32'h1000; lane_stride = 32'h100; words_per_lane = 16'd1;
        for (int l = 0; l < NL; l++) begin
            rdp[l] = 0;
            wrp[l] = 0;
        end
        drive();

        vecs[0] = mk(1, 32'h1000, 32'h100, 0, 2, 64'h2222_1111, 0, 0, 64'h0,
                     1, {32'h0, 32'h1000}, {32'h0, 32'h2222_1111});
        vecs[1] = mk(1, 32'h1000, 32'h100, 3, 2, 64'hA031_A030, 7, 2, 64'hB071_B070,
                     2, {32'h1700, 32'h1300}, {32'hB071_B070, 32'hA031_A030});
        vecs[2] = mk(1, 32'h1000, 32'h100, 31, 2, 64'h1F01_1F00, 2, 2, 64'h0201_0200,
                     2, {32'h2F00, 32'h1200}, {32'h1F01_1F00, 32'h0201_0200});
        vecs[3] = mk(1, 32'hFFFF_FF00, 32'h8000_0000, 3, 2, 64'h0301_0300, 4, 2, 64'h0401_0400,
                     2, {32'hFFFF_FF00, 32'h7FFF_FF00}, {32'h0401_0400, 32'h0301_0300});
        vecs[4] = mk(2, 32'h2000, 32'h40, 6, 4, 64'h6003_6002_6001_6000, 0, 0, 64'h0,
                     2, {32'h2184, 32'h2180}, {32'h6003_6002, 32'h6001_6000});
        vecs[5] = mk(0, 32'h1000, 32'h100, 1, 2, 64'h1101_1100, 0, 0, 64'h0,
                     0, 64'h0, 64'h0);

        do_reset();
        check("rst_pop_en", pop_opsum_en, 0);
        check("rst_pop_mod", pop_opsum_mod, 0);
        check("rst_glb_we", glb_we, 0);
        check("rst_glb_addr", glb_addr, 0);
        check("rst_glb_wdata", glb_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < vecs[i].na; j++) push(vecs[i].la, vecs[i].va[16*j +: 16]);
            for (int j = 0; j < vecs[i].nb; j++) push(vecs[i].lb, vecs[i].vb[16*j +: 16]);
            start_drain(vecs[i].wpl, vecs[i].base, vecs[i].stride);
            repeat (30) tick();
            check($sformatf("vec%0d_nwrites", i), wr_n, vecs[i].nexp);
            for (int k = 0; k < vecs[i].nexp; k++) begin
                check($sformatf("vec%0d_addr%0d", i, k), wr_addr[k], vecs[i].ea[k]);
                check($sformatf("vec%0d_data%0d", i, k), wr_data[k], vecs[i].ed[k]);
            end
            check($sformatf("vec%0d_pops", i), npops, 2 * vecs[i].nexp);
            check($sformatf("vec%0d_busy", i), busy, (vecs[i].wpl != 0));
            check($sformatf("vec%0d_ndone", i), ndone, (vecs[i].wpl == 0));
        end

        // GLB backpressure
        do_reset();
        glb_ready = 1'b0;
        push(9, 16'h9000);
        push(9, 16'h9001);
        start_drain(1, 32'h1000, 32'h100);
        for (int c = 0; c < 20 && !glb_we; c++) tick();
        check("bp_we_up", glb_we, 1);
        p0 = npops;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("bp_we_c%0d", c), glb_we, 1);
            check($sformatf("bp_addr_c%0d", c), glb_addr, 32'h1900);
            check($sformatf("bp_wdata_c%0d", c), glb_wdata, 32'h9001_9000);
        end
        check("bp_no_pops", npops - p0, 0);
        check("bp_no_write", wr_n, 0);
        glb_ready = 1'b1;
        tick();
        check("bp_accept_n", wr_n, 1);
        check("bp_accept_addr", wr_addr[0], 32'h1900);
        check("bp_accept_data", wr_data[0], 32'h9001_9000);
        check("bp_we_drop", glb_we, 0);

        // Hi-half starvation
        do_reset();
        push(5, 16'h5555);
        start_drain(1, 32'h1000, 32'h100);
        repeat (6) tick();
        check("starve_pops", npops, 1);
        check("starve_we", glb_we, 0);
        check("starve_busy", busy, 1);
        push(5, 16'h5AAA);
        for (int c = 0; c < 10 && wr_n == 0; c++) tick();
        check("starve_nwrites", wr_n, 1);
        check("starve_addr", wr_addr[0], 32'h1500);
        check("starve_data", wr_data[0], 32'h5AAA_5555);
        check("starve_pops_end", npops, 2);

        // Zero-length drain timing
        do_reset();
        push(1, 16'h0111);
        push(1, 16'h0112);
        start_drain(0, 32'h1000, 32'h100);
        check("zl_done_c1", done, 0);
        tick();
        check("zl_done_c2", done, 1);
        tick();
        check("zl_done_c3", done, 0);
        check("zl_busy", busy, 0);
        check("zl_pops", npops, 0);
        check("zl_writes", wr_n, 0);

        // Full drain with random pushes, random ready, and an ignored mid-drain start
        do_reset();
        start_drain(2, 32'h1000, 32'h100);
        for (int c = 0; c < 3000 && ndone == 0; c++) begin
            for (int l = 0; l < NL; l++) begin
                if (wrp[l] < 4 && $urandom_range(3) == 0) push(l, {8'(l), 8'(wrp[l])});
            end
            glb_ready = ($urandom_range(3) != 0);
            if (c == 40) begin
                start = 1'b1;
                words_per_lane = 16'd5;
                base_addr = 32'h0;
            end
            tick();
            start = 1'b0;
        end
        glb_ready = 1'b1;
        repeat (5) tick();
        check("fd_ndone", ndone, 1);
        check("fd_done_low", done, 0);
        check("fd_busy", busy, 0);
        check("fd_nwrites", wr_n, 64);
        seen = '0;
        bad = 0;
        for (int k = 0; k < wr_n; k++) begin
            off = wr_addr[k] - 32'h1000;
            ln = int'(off[12:8]);
            w = int'(off[7:2]);
            if (wr_addr[k] < 32'h1000 || off >= 32'h2000 || w >= 2 || off[1:0] != 2'b00 || seen[ln*2+w]) begin
                bad++;
            end else begin
                seen[ln*2+w] = 1'b1;
                l8 = 8'(ln);
                expd = {l8, 8'(2*w+1), l8, 8'(2*w)};
                if (wr_data[k] != expd) bad++;
            end
        end
        check("fd_bad_writes", bad, 0);
        check("fd_all_seen", seen, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset mid-WRITE with a nonzero word counter
        glb_ready = 1'b1;
        for (int j = 0; j < 4; j++) push(0, 16'h0A00 + 16'(j));
        start_drain(2, 32'h1000, 32'h100);
        for (int c = 0; c < 30 && wr_n < 65; c++) tick();
        glb_ready = 1'b0;
        for (int c = 0; c < 30 && !glb_we; c++) tick();
        check("rmw_we_before", glb_we, 1);
        check("rmw_wcnt_pre", dut.wcnt[0], 1);
        p0 = npops;
        rst = 1'b1;
        tick();
        check("rmw_we", glb_we, 0);
        check("rmw_busy", busy, 0);
        check("rmw_addr", glb_addr, 0);
        check("rmw_wdata", glb_wdata, 0);
        s = 0;
        for (int l = 0; l < NL; l++) s += int'(dut.wcnt[l]);
        check("rmw_wcnt_zero", s, 0);
        check("rmw_no_pop", npops - p0, 0);
        rst = 1'b0;
        tick();
        check("rmw_idle_busy", busy, 0);

        // Reset while ARB would otherwise pop an eligible lane
        do_reset();
        push(2, 16'h0202);
        push(2, 16'h0203);
        start_drain(1, 32'h1000, 32'h100);
        p0 = npops;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rarb_no_pop", npops - p0, 0);
        check("rarb_busy", busy, 0);

        check("no_pop_on_empty", viol_empty, 0);
        check("pop_onehot", viol_onehot, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
